// File: rtl/serial_adder_rx_pkg.sv
// Shared constants for the serial adder receiver: FSM state encodings and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The encodings here are fixed. ST_IDLE=0, ST_RUN=1 and ST_DONE=2.
// Encoding 3 is unused, and the FSM recovers from it into ST_IDLE.
package serial_adder_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

endpackage : serial_adder_rx_pkg

// File: rtl/serial_adder_rx_fa.sv
// One-bit full adder cell used as the single arithmetic stage of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the cell has no state and no handshake.
//
// Ports:
//   a, b, cin : operand bits and carry in
//   s, cout   : sum bit and carry out (majority of the three inputs)
module full_adder_cell
    import serial_adder_rx_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/serial_adder_rx.sv
// Bit-serial operand receiver. It adds two LSB-first operands with one full-adder cell and a carry flop,
// then deserialises the sum into a WIDTH-bit word with carry/overflow flags.
// Latency: done pulses 1 cycle after the WIDTH-th accepted beat (minimum start-to-done is WIDTH+1 cycles).
// Backpressure: none. bit_valid gaps of any length stall the operation, and start aborts and restarts it.
//
// Optional feature macro: SERIAL_SUB_EN.
//   When it is defined, sub is latched with start and the block computes A - B as A + ~B + 1.
//   When it is undefined, sub is ignored and the block only adds.
//
// Ports:
//   clk, reset          : rising-edge clock; asynchronous active-high reset
//   start               : level-sampled request to begin (or restart) an operation
//   bit_valid           : a_bit/b_bit hold a valid beat this cycle
//   a_bit, b_bit        : operand serial bits, LSB first
//   sub                 : subtract mode, sampled with start
//   sum                 : assembled result; held until the next accepted start
//   carry_out, overflow : MSB-stage carry out and signed overflow
//   busy, done          : busy is high in RUN; done is a one-cycle pulse when the result is complete
module serial_adder_rx
    import serial_adder_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    // Index of the last (MSB) beat. Accepting this beat completes the operation.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             b_eff;      // B operand bit after optional inversion
    logic             cin_start;  // carry preset applied when an operation begins
    logic             fa_s;
    logic             fa_cout;
    logic             load;       // an accepted start in this cycle

`ifdef SERIAL_SUB_EN
    logic             sub_q, sub_d;

    // The latched mode is used for the whole operation, so sub may change after start.
    assign b_eff     = b_bit ^ sub_q;
    assign cin_start = sub;
`else
    // Add-only build. sub is tied off here, so the carry preset is always zero.
    assign b_eff     = b_bit;
    assign cin_start = sub & 1'b0;
`endif

    full_adder_cell u_fa (
        .a    (a_bit),
        .b    (b_eff),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        load        = 1'b0;
`ifdef SERIAL_SUB_EN
        sub_d       = sub_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // bit_valid is ignored here, even when it coincides with start.
                if (start) begin
                    load = 1'b1;
                end
            end

            ST_RUN: begin
                // start takes priority: any beat presented in the same cycle is dropped.
                if (start) begin
                    load = 1'b1;
                end else if (bit_valid) begin
                    sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                    carry_d = fa_cout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d     = ST_DONE;
                        carry_out_d = fa_cout;
                        // In the MSB stage the old carry is the carry into the MSB.
                        overflow_d  = carry_q ^ fa_cout;
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                // Unused encoding: drop back to IDLE without acting on start.
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d = ST_RUN;
            sum_d   = '0;
            cnt_d   = '0;
            carry_d = cin_start;
`ifdef SERIAL_SUB_EN
            sub_d   = sub;
`endif
        end

        // Status flags are registered copies of the next state, so busy and done are exactly aligned with RUN and DONE.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef SERIAL_SUB_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`endif

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : serial_adder_rx
